// File: rtl/div_disp_pkg.sv
// Shared types and constants for the divider result display.
// Digit codes 0..9 are BCD; codes A..F carry the non-numeric glyphs.
package div_disp_pkg;

    typedef enum logic {IDLE, CONV} state_t;

    localparam int DIG_IDX_W = 2;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_R     = 7'h2F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    // Active-low {g,f,e,d,c,b,a}; element 0 is the rightmost entry.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [3:0] CODE_E     = 4'hA;
    localparam logic [3:0] CODE_R     = 4'hB;
    localparam logic [3:0] CODE_DASH  = 4'hC;
    localparam logic [3:0] CODE_BLANK = 4'hF;

    // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
    function automatic logic [7:0] dd_adjust(input logic [7:0] bcd);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = bcd[7:4];
        lo = bcd[3:0];
        if (hi >= 4'd5) hi = hi + 4'd3;
        if (lo >= 4'd5) lo = lo + 4'd3;
        return {hi, lo};
    endfunction

endpackage

// File: rtl/div_result_display_seg7_decoder.sv
// Combinational digit-code to active-low 7-segment decoder.
// Codes 0..9 map to numerals; A/B/C map to E, r, dash; anything else is blank.
module seg7_decoder
    import div_disp_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (code_i)
            4'd0:      seg_o = SEG_TABLE[0];
            4'd1:      seg_o = SEG_TABLE[1];
            4'd2:      seg_o = SEG_TABLE[2];
            4'd3:      seg_o = SEG_TABLE[3];
            4'd4:      seg_o = SEG_TABLE[4];
            4'd5:      seg_o = SEG_TABLE[5];
            4'd6:      seg_o = SEG_TABLE[6];
            4'd7:      seg_o = SEG_TABLE[7];
            4'd8:      seg_o = SEG_TABLE[8];
            4'd9:      seg_o = SEG_TABLE[9];
            CODE_E:    seg_o = SEG_E;
            CODE_R:    seg_o = SEG_R;
            CODE_DASH: seg_o = SEG_DASH;
            default:   seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/div_result_display.sv
// Divider result display: valid/ready capture, 4-step double-dabble, 4-digit scan.
// Optional DIV_DISP_ERR_BLINK_EN blinks "Err-" every BLINK_DIV frames.
module div_result_display
    import div_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    output logic       ready_out,
    input  logic [3:0] q_in,
    input  logic [3:0] r_in,
    input  logic       err_in,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       disp_valid
);

    localparam int SCAN_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    if (SCAN_DIV < 2 || BLINK_DIV < 1) begin : g_bad_param
        $error("div_result_display: SCAN_DIV must be >= 2 and BLINK_DIV >= 1");
    end

    // Handshake: a result transfers on a rising edge where valid_in && ready_out.
    state_t                state_q;
    logic                  ready_q;
    logic [3:0]            qbin_q, rbin_q;
    logic                  err_q;
    logic [7:0]            qbcd_q, rbcd_q, qbcd_d, rbcd_d;
    logic [1:0]            iter_q;
    logic [3:0][3:0]       dig_q, dig_d;
    logic                  disp_valid_q, disp_err_q;
    logic [SCAN_W-1:0]     scan_cnt_q;
    logic [DIG_IDX_W-1:0]  idx_q;
    logic [6:0]            seg_q, dec_seg;
    logic [3:0]            an_q, cur_code;
    logic                  accept, scan_wrap, blank_now;

    assign accept    = (state_q == IDLE) && valid_in;
    assign scan_wrap = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));

    always_comb begin
        qbcd_d = (dd_adjust(qbcd_q) << 1) | {7'd0, qbin_q[3]};
        rbcd_d = (dd_adjust(rbcd_q) << 1) | {7'd0, rbin_q[3]};
        // dig_d[0] is the leftmost digit so it lines up with scan index 0.
        if (err_q) begin
            dig_d = {CODE_DASH, CODE_R, CODE_R, CODE_E};
        end else begin
            dig_d[0] = (qbcd_d[7:4] == 4'd0) ? CODE_BLANK : qbcd_d[7:4];
            dig_d[1] = qbcd_d[3:0];
            dig_d[2] = (rbcd_d[7:4] == 4'd0) ? CODE_BLANK : rbcd_d[7:4];
            dig_d[3] = rbcd_d[3:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            qbin_q       <= '0;
            rbin_q       <= '0;
            err_q        <= 1'b0;
            qbcd_q       <= '0;
            rbcd_q       <= '0;
            iter_q       <= '0;
            dig_q        <= {4{CODE_BLANK}};
            disp_valid_q <= 1'b0;
            disp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        qbin_q  <= q_in;
                        rbin_q  <= r_in;
                        err_q   <= err_in;
                        qbcd_q  <= '0;
                        rbcd_q  <= '0;
                        iter_q  <= '0;
                        ready_q <= 1'b0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    qbcd_q <= qbcd_d;
                    rbcd_q <= rbcd_d;
                    qbin_q <= {qbin_q[2:0], 1'b0};
                    rbin_q <= {rbin_q[2:0], 1'b0};
                    iter_q <= iter_q + 2'd1;
                    if (iter_q == 2'd3) begin
                        dig_q        <= dig_d;
                        disp_valid_q <= 1'b1;
                        disp_err_q   <= err_q;
                        ready_q      <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef DIV_DISP_ERR_BLINK_EN
    localparam int FRAME_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    logic [FRAME_W-1:0] frame_cnt_q;
    logic               blank_phase_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q   <= '0;
            blank_phase_q <= 1'b0;
        end else if (accept) begin
            frame_cnt_q   <= '0;
            blank_phase_q <= 1'b0;
        end else if (scan_wrap && idx_q == DIG_IDX_W'(3)) begin
            if (frame_cnt_q == FRAME_W'(BLINK_DIV - 1)) begin
                frame_cnt_q   <= '0;
                blank_phase_q <= ~blank_phase_q;
            end else begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
        end
    end

    assign blank_now = disp_err_q && blank_phase_q;
`else
    assign blank_now = 1'b0;
`endif

    assign cur_code = (!disp_valid_q || blank_now) ? CODE_BLANK : dig_q[idx_q];

    seg7_decoder u_dec (
        .code_i (cur_code),
        .seg_o  (dec_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= 4'hF;
        end else begin
            scan_cnt_q <= scan_wrap ? '0 : scan_cnt_q + 1'b1;
            if (scan_wrap) idx_q <= idx_q + 1'b1;
            seg_q <= dec_seg;
            an_q  <= ~(4'b1000 >> idx_q);
        end
    end

    assign ready_out  = ready_q;
    assign disp_valid = disp_valid_q;
    assign seg        = seg_q;
    assign an         = an_q;

endmodule

// File: tb/tb_div_result_display.sv
// Directed bench for div_result_display with SCAN_DIV=4, BLINK_DIV=2.
module tb_div_result_display;

  localparam int SCAN_DIV  = 4;
  localparam int BLINK_DIV = 2;

  typedef logic [0:3][6:0] frame_t;
  typedef struct {
    logic [3:0] q;
    logic [3:0] r;
    logic       err;
    frame_t     exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid_in = 1'b0;
  logic       ready_out;
  logic [3:0] q_in = '0;
  logic [3:0] r_in = '0;
  logic       err_in = 1'b0;
  logic [6:0] seg;
  logic [3:0] an;
  logic       disp_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  int         acc_cyc[$];
  logic [6:0] seg_ref [10];

  div_result_display #(.SCAN_DIV(SCAN_DIV), .BLINK_DIV(BLINK_DIV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .q_in       (q_in),
    .r_in       (r_in),
    .err_in     (err_in),
    .seg        (seg),
    .an         (an),
    .disp_valid (disp_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic frame_t model_frame(input int q, input int r, input bit e);
    frame_t f;
    if (e) begin
      f = {7'h06, 7'h2F, 7'h2F, 7'h3F};
    end else begin
      f[0] = (q / 10 == 0) ? 7'h7F : seg_ref[q / 10];
      f[1] = seg_ref[q % 10];
      f[2] = (r / 10 == 0) ? 7'h7F : seg_ref[r / 10];
      f[3] = seg_ref[r % 10];
    end
    return f;
  endfunction

  task automatic reset_values(input string tag);
    check({tag, "_seg"}, seg, 7'h7F);
    check({tag, "_an"}, an, 4'hF);
    check({tag, "_ready"}, ready_out, 1'b1);
    check({tag, "_disp_valid"}, disp_valid, 1'b0);
  endtask

  // Called right after a negedge; releases reset and checks one blank scan frame.
  task automatic release_scan(input string tag);
    logic [3:0] e_an;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      @(negedge clk);
      e_an = 4'b1111 ^ (4'b1000 >> (i / SCAN_DIV));
      check($sformatf("%s_scan_an%0d", tag, i), an, e_an);
      check($sformatf("%s_scan_seg%0d", tag, i), seg, 7'h7F);
    end
  endtask

  task automatic capture(output frame_t fr);
    fr = 'x;
    for (int i = 0; i < 4 * SCAN_DIV; i++) begin
      case (an)
        4'h7: fr[0] = seg;
        4'hB: fr[1] = seg;
        4'hD: fr[2] = seg;
        4'hE: fr[3] = seg;
        default: check("an_legal", an, 4'h7);
      endcase
      @(negedge clk);
    end
  endtask

  task automatic check_frame(input string name, input frame_t exp);
    frame_t fr;
    capture(fr);
    for (int d = 0; d < 4; d++)
      check($sformatf("%s_dig%0d", name, d), fr[d], exp[d]);
    check({name, "_disp_valid"}, disp_valid, 1'b1);
  endtask

  // driver: called at a negedge, one-cycle valid pulse, then ready timing and frame.
  task automatic send(input string name, input logic [3:0] q, input logic [3:0] r,
                      input logic e, input frame_t exp);
    int waited = 0;
    while (ready_out !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) check({name, "_ready_timeout"}, ready_out, 1'b1);
    valid_in = 1'b1; q_in = q; r_in = r; err_in = e;
    @(negedge clk);
    valid_in = 1'b0;
    q_in = 4'($urandom_range(0, 15));
    r_in = 4'($urandom_range(0, 15));
    err_in = 1'($urandom_range(0, 1));
    check({name, "_ready_low1"}, ready_out, 1'b0);
    for (int k = 2; k <= 4; k++) begin
      @(negedge clk);
      check($sformatf("%s_ready_low%0d", name, k), ready_out, 1'b0);
    end
    @(negedge clk);
    check({name, "_ready_back"}, ready_out, 1'b1);
    @(negedge clk);
    check_frame(name, exp);
  endtask

  vec_t vecs[7];

  initial begin
    frame_t f;
    int     n_acc;

    seg_ref[0] = 7'h40; seg_ref[1] = 7'h79; seg_ref[2] = 7'h24; seg_ref[3] = 7'h30;
    seg_ref[4] = 7'h19; seg_ref[5] = 7'h12; seg_ref[6] = 7'h02; seg_ref[7] = 7'h78;
    seg_ref[8] = 7'h00; seg_ref[9] = 7'h10;

    vecs[0] = '{q: 4'd13, r: 4'd2,  err: 1'b0, exp: {7'h79, 7'h30, 7'h7F, 7'h24}};
    vecs[1] = '{q: 4'd15, r: 4'd15, err: 1'b1, exp: {7'h06, 7'h2F, 7'h2F, 7'h3F}};
    vecs[2] = '{q: 4'd10, r: 4'd0,  err: 1'b0, exp: {7'h79, 7'h40, 7'h7F, 7'h40}};
    vecs[3] = '{q: 4'd0,  r: 4'd15, err: 1'b0, exp: {7'h7F, 7'h40, 7'h79, 7'h12}};
    vecs[4] = '{q: 4'd7,  r: 4'd9,  err: 1'b0, exp: {7'h7F, 7'h78, 7'h7F, 7'h10}};
    vecs[5] = '{q: 4'd12, r: 4'd4,  err: 1'b0, exp: {7'h79, 7'h24, 7'h7F, 7'h19}};
    vecs[6] = '{q: 4'd8,  r: 4'd11, err: 1'b0, exp: {7'h7F, 7'h00, 7'h79, 7'h79}};

    // power-on reset
    #1 rst_n = 1'b0;
    #2 reset_values("por");
    @(negedge clk);
    release_scan("por");

    // table-driven results
    for (int i = 0; i < 7; i++)
      send($sformatf("vec%0d", i), vecs[i].q, vecs[i].r, vecs[i].err, vecs[i].exp);

    // valid_in held high: accepts land every 5 cycles, CONV-time inputs ignored
    valid_in = 1'b1;
    err_in = 1'b0;
    for (int c = 0; c < 22; c++) begin
      q_in = 4'((c * 7 + 3) % 16);
      r_in = 4'((c * 5 + 1) % 16);
      if (ready_out === 1'b1) begin
        exp_q.push_back({q_in, r_in});
        acc_cyc.push_back(c);
      end
      @(negedge clk);
    end
    valid_in = 1'b0;
    n_acc = exp_q.size();
    check("hold_accept_count", n_acc, 5);
    for (int i = 1; i < acc_cyc.size(); i++)
      check($sformatf("hold_interval%0d", i), acc_cyc[i] - acc_cyc[i - 1], 5);
    repeat (6) @(negedge clk);
    if (n_acc > 0) begin
      f = model_frame(int'(exp_q[n_acc - 1][7:4]), int'(exp_q[n_acc - 1][3:0]), 1'b0);
      check_frame("hold_last", f);
    end

    // reset during the second CONV cycle
    valid_in = 1'b1; q_in = 4'd9; r_in = 4'd3; err_in = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    check("midrst_conv", ready_out, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_values("midrst");
    @(negedge clk);
    release_scan("midrst");
    check("midrst_disp_valid", disp_valid, 1'b0);

    // recovery after reset
    send("recover", 4'd13, 4'd2, 1'b0, vecs[0].exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "timeout");
  end

endmodule
